// File: rtl/vgseq_pkg.sv
// vgseq_pkg: shared types and constants for the vector generator PROM
// microsequencer.
//   state_e      - sequencer FSM states
//   ROM_AW/DW    - state PROM geometry (256 x 4)
//   USTATE_DONE  - PROM code meaning "opcode complete"
//   USTATE_HALT  - PROM code meaning "stop the vector generator"
package vgseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOOK,
    APPLY,
    HALTED
  } state_e;

  localparam int ROM_AW = 8;
  localparam int ROM_DW = 4;

  localparam logic [ROM_DW-1:0] USTATE_DONE = 4'h0;
  localparam logic [ROM_DW-1:0] USTATE_HALT = 4'hF;

endpackage

// File: rtl/vgseq_wdog.sv
// vgseq_wdog: micro-step counter for the sequencer watchdog.
// The module only exists when VGSEQ_WDOG_EN is defined; the default build
// has no step limit and no counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart the count (takes priority over inc)
//   inc         one micro-step applied this cycle
//   trip        this step is the MAX_STEPS-th since the last clear
`ifdef VGSEQ_WDOG_EN
module vgseq_wdog #(
  parameter int MAX_STEPS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic trip
);

  localparam int W = $clog2(MAX_STEPS + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Compare the pre-increment count so the trip lines up with the step
  // that would take the count to MAX_STEPS.
  assign trip = inc && (cnt_q == W'(MAX_STEPS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/vg_prom_sequencer.sv
// vg_prom_sequencer: microsequencer driving the 256x4 synchronous state PROM.
// Each opcode from the fetch unit is walked through PROM micro-states:
// address = {halt_pend, opcode, ustate}, data = next ustate. Code 0 ends the
// opcode, code F halts the vector generator.
// Optional feature: define VGSEQ_WDOG_EN to enable the MAX_STEPS watchdog
// (sticky err, forced halt). Without it err is tied low.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   go                    start pulse (IDLE/HALTED only)
//   halt_req              halt level, sampled with the opcode in FETCH
//   op_valid, opcode      opcode handshake in; op_ready pulses on consume
//   rom_addr, rom_cs      PROM address (registered) and select (LOOK)
//   rom_dout              PROM data, valid in APPLY
//   ustate, ustate_stb    current micro-state and per-step strobe
//   busy, done, err       activity, halt-entry pulse, watchdog error
module vg_prom_sequencer
  import vgseq_pkg::*;
#(
  parameter int MAX_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              halt_req,
  input  logic              op_valid,
  input  logic [2:0]        opcode,
  output logic              op_ready,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [ROM_DW-1:0] rom_dout,
  output logic [3:0]        ustate,
  output logic              ustate_stb,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [3:0]        ustate_q, ustate_d;
  logic [2:0]        op_lat_q, op_lat_d;
  logic              halt_pend_q, halt_pend_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  logic start;   // accepted go: clears err and the step count
  logic wd_inc;
  logic wd_trip;
  logic wd_err;

  always_comb begin
    state_d     = state_q;
    ustate_d    = ustate_q;
    op_lat_d    = op_lat_q;
    halt_pend_d = halt_pend_q;
    rom_addr_d  = rom_addr_q;
    op_ready    = 1'b0;
    rom_cs      = 1'b0;
    ustate_stb  = 1'b0;
    done        = 1'b0;
    start       = 1'b0;
    wd_inc      = 1'b0;
    wd_err      = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (go) begin
          start       = 1'b1;
          ustate_d    = '0;
          halt_pend_d = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (op_valid) begin
          op_lat_d    = opcode;
          halt_pend_d = halt_req;
          // Use halt_req directly: halt_pend_q is not updated until this edge.
          rom_addr_d  = {halt_req, opcode, ustate_q};
          state_d     = LOOK;
        end
      end
      LOOK: begin
        rom_cs  = 1'b1;
        state_d = APPLY;
      end
      APPLY: begin
        ustate_d   = rom_dout;
        ustate_stb = 1'b1;
        wd_inc     = 1'b1;
        if (rom_dout == USTATE_DONE) begin
          op_ready = 1'b1;
          state_d  = FETCH;
        end else if (rom_dout == USTATE_HALT) begin
          op_ready = 1'b1;
          done     = 1'b1;
          state_d  = HALTED;
        end else if (wd_trip) begin
          // Runaway opcode: halt without consuming it.
          wd_err  = 1'b1;
          done    = 1'b1;
          state_d = HALTED;
        end else begin
          rom_addr_d = {halt_pend_q, op_lat_q, rom_dout};
          state_d    = LOOK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ustate_q    <= '0;
      op_lat_q    <= '0;
      halt_pend_q <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ustate_q    <= ustate_d;
      op_lat_q    <= op_lat_d;
      halt_pend_q <= halt_pend_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

`ifdef VGSEQ_WDOG_EN
  logic err_q;

  // Any terminating step (code 0/F or trip) restarts the count.
  vgseq_wdog #(.MAX_STEPS(MAX_STEPS)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || (state_q == APPLY && state_d != LOOK)),
    .inc   (wd_inc),
    .trip  (wd_trip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (start)  err_q <= 1'b0;
    else if (wd_err) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic wdog_unused;

  assign wd_trip     = 1'b0;
  assign err         = 1'b0;
  assign wdog_unused = start ^ wd_inc ^ wd_err ^ (MAX_STEPS > 0);
`endif

  assign rom_addr = rom_addr_q;
  assign ustate   = ustate_q;
  assign busy     = (state_q == FETCH) || (state_q == LOOK) || (state_q == APPLY);

endmodule

// File: tb/tb_vg_prom_sequencer.sv
// Directed bench for vg_prom_sequencer with a registered PROM model and a
// scoreboard of expected micro-state updates.
module tb_vg_prom_sequencer;

`ifdef VGSEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int MAXS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       halt_req = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = '0;
  logic       op_ready;
  logic [7:0] rom_addr;
  logic       rom_cs;
  logic [3:0] rom_dout = '0;
  logic [3:0] ustate;
  logic       ustate_stb;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem [256];
  logic [3:0] exp_q [$];
  logic       mon_en = 1'b1;
  logic       pend = 1'b0;
  logic [3:0] pend_val = '0;

  vg_prom_sequencer #(.MAX_STEPS(MAXS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .halt_req   (halt_req),
    .op_valid   (op_valid),
    .opcode     (opcode),
    .op_ready   (op_ready),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_dout   (rom_dout),
    .ustate     (ustate),
    .ustate_stb (ustate_stb),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Synchronous PROM, one-cycle read latency.
  always @(posedge clk) if (rom_cs) rom_dout <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Scoreboard: each strobe pops the expected next micro-state, which must
  // appear on ustate one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      chk("sb_ustate", {28'd0, ustate}, {28'd0, pend_val});
      pend = 1'b0;
    end
    if (ustate_stb && mon_en) begin
      if (exp_q.size() == 0) chk("sb_extra_stb", 32'(exp_q.size()), 32'd1);
      else begin
        pend_val = exp_q.pop_front();
        pend = 1'b1;
      end
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    mem[8'h20] = 4'h5; mem[8'h25] = 4'h0;   // opcode 2: 0 -> 5 -> done
    mem[8'h90] = 4'hF;                      // halt page, opcode 1
    mem[8'h30] = 4'h7; mem[8'h37] = 4'h0;   // opcode 3: 0 -> 7 -> done
    mem[8'h40] = 4'h1; mem[8'h41] = 4'h2; mem[8'h42] = 4'h1; // opcode 4 loop

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_ustate", ustate, 0);
    chk("rst_outs", {op_ready, rom_cs, ustate_stb, done, err}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Opcode 2: two micro-steps then back to FETCH
    go_pulse();
    chk("fetch_busy", busy, 1);
    exp_q.push_back(4'h5); exp_q.push_back(4'h0);
    op_valid = 1'b1; opcode = 3'd2;
    tick();                                   // accepted -> LOOK
    chk("t2_addr0", rom_addr, 8'h20);
    chk("t2_cs", rom_cs, 1);
    chk("t2_stb_early", ustate_stb, 0);
    chk("t2_rdy_accept", op_ready, 0);
    tick();                                   // APPLY (N+2)
    chk("t2_stb1", ustate_stb, 1);
    chk("t2_rdy1", op_ready, 0);
    tick();
    chk("t2_addr1", rom_addr, 8'h25);
    chk("t2_cs1", rom_cs, 1);
    tick();                                   // APPLY (N+4)
    chk("t2_stb2", ustate_stb, 1);
    chk("t2_rdy2", op_ready, 1);
    op_valid = 1'b0;
    tick();
    chk("t2_fetch_busy", busy, 1);
    chk("t2_fetch_cs", rom_cs, 0);
    chk("t2_ustate", ustate, 0);

    // Halt page: halt_req with opcode 1
    exp_q.push_back(4'hF);
    halt_req = 1'b1; op_valid = 1'b1; opcode = 3'd1;
    tick();
    halt_req = 1'b0;
    chk("t3_addr", rom_addr, 8'h90);
    tick();
    chk("t3_done", done, 1);
    chk("t3_rdy", op_ready, 1);
    op_valid = 1'b0;
    tick();
    chk("t3_busy", busy, 0);
    chk("t3_done_pulse", done, 0);
    chk("t3_ustate", ustate, 4'hF);
    tick();
    chk("t3_still_halted", busy, 0);
    go_pulse();
    chk("t3_go_busy", busy, 1);
    chk("t3_go_ustate", ustate, 0);

    // Idle FETCH: no op_valid for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_cs", rom_cs, 0);
      chk("t4_stb", ustate_stb, 0);
      chk("t4_busy", busy, 1);
    end

    // go during LOOK is ignored (also proves halt_pend was cleared)
    exp_q.push_back(4'h7); exp_q.push_back(4'h0);
    op_valid = 1'b1; opcode = 3'd3;
    tick();
    go = 1'b1;
    chk("t6_addr0", rom_addr, 8'h30);
    tick();
    go = 1'b0;
    chk("t6_stb", ustate_stb, 1);
    tick();
    chk("t6_addr1", rom_addr, 8'h37);
    tick();
    chk("t6_rdy", op_ready, 1);
    op_valid = 1'b0;
    tick();
    chk("t6_busy", busy, 1);

    // Looping opcode: watchdog trips after MAXS steps, or runs on
    op_valid = 1'b1; opcode = 3'd4;
    for (int k = 0; k < (WD ? MAXS : 6); k++) exp_q.push_back((k % 2 == 0) ? 4'h1 : 4'h2);
    tick();
    for (int k = 0; k < (WD ? MAXS : 6); k++) begin
      chk("t5_cs", rom_cs, 1);
      tick();
      chk("t5_stb", ustate_stb, 1);
      chk("t5_rdy", op_ready, 0);
      chk("t5_done", done, 32'(WD && k == (WD ? MAXS : 6) - 1));
      tick();
    end
    chk("t5_err", err, 32'(WD));
    chk("t5_busy", busy, 32'(!WD));
    mon_en = 1'b0;
    if (WD) go_pulse();

    // Async reset in the middle of APPLY
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ustate_stb) seen = 1'b1;
      else tick();
    end
    chk("t1_reach_apply", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_addr", rom_addr, 0);
    chk("t1_ustate", ustate, 0);
    chk("t1_outs", {op_ready, rom_cs, ustate_stb, done, err}, 0);
    op_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_idle", busy, 0);
    go_pulse();
    chk("t1_go_fetch", busy, 1);
    chk("t1_go_cs", rom_cs, 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
